// File: rtl/alt_vipitc130_common_trigger_resp.sv
// Trigger responder: queues trigger pulses in a saturating counter and runs one
// start/done transaction per trigger, closing each with an ack (and timeout) pulse.
module alt_vipitc130_common_trigger_resp #(
    parameter int PENDING_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger_in,
    input  logic                     enable,
    input  logic                     done_in,
    input  logic                     clear_overflow,
    output logic                     start,
    output logic                     busy,
    output logic                     ack,
    output logic                     timeout,
    output logic [PENDING_WIDTH-1:0] pending,
    output logic                     overflow,
    output logic [1:0]               state_dbg
);

    localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
        (TIMEOUT_CYCLES > 0) ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   timeout_flag;
    logic                   expire;
    logic                   inc;
    logic                   dec;

    // Downstream handshake: start is a one-cycle request; the engine answers
    // with done_in at any later cycle, and done_in is only honoured in WAIT.
    always_comb begin
        state_next = state;
        expire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && (pending != '0)) begin
                    state_next = S_START;
                end
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (done_in) begin
                    state_next = S_ACK;
                end else if ((TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST)) begin
                    state_next = S_ACK;
                    expire     = 1'b1;
                end
            end
            S_ACK: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_START) begin
                timer <= '0;
            end else if ((state == S_WAIT) && (state_next == S_WAIT)) begin
                timer <= timer + 1'b1;
            end
            if (expire) begin
                timeout_flag <= 1'b1;
            end else if (state == S_ACK) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    assign inc = trigger_in;
    assign dec = (state == S_START);

    // A trigger arriving while saturated is lost but remembered in overflow;
    // a simultaneous set beats clear_overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (pending != PEND_MAX) begin
                    pending <= pending + 1'b1;
                end
            end else if (dec && !inc) begin
                pending <= pending - 1'b1;
            end
            if (inc && !dec && (pending == PEND_MAX)) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign start     = (state == S_START);
    assign busy      = (state == S_START) || (state == S_WAIT);
    assign ack       = (state == S_ACK);
    assign timeout   = (state == S_ACK) && timeout_flag;
    assign state_dbg = state;

endmodule

// File: tb/tb_alt_vipitc130_common_trigger_resp.sv
// Randomised and directed bench for alt_vipitc130_common_trigger_resp against a
// transaction-age reference model.
module tb_alt_vipitc130_common_trigger_resp;

    localparam int PW   = 2;
    localparam int T    = 5;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger_in = 1'b0;
    logic          enable = 1'b0;
    logic          done_in = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          start;
    logic          busy;
    logic          ack;
    logic          timeout;
    logic [PW-1:0] pending;
    logic          overflow;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Reference model: a transaction is "active" from its start cycle (age 0)
    // until it ends; age counts cycles since start.
    int        m_pend;
    bit        m_ovf;
    bit        m_act;
    int        m_age;
    bit        m_ack;
    bit        m_to;
    logic [0:0] exp_q[$];

    alt_vipitc130_common_trigger_resp #(
        .PENDING_WIDTH (PW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trigger_in    (trigger_in),
        .enable        (enable),
        .done_in       (done_in),
        .clear_overflow(clear_overflow),
        .start         (start),
        .busy          (busy),
        .ack           (ack),
        .timeout       (timeout),
        .pending       (pending),
        .overflow      (overflow),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 0;
            m_ovf  <= 1'b0;
            m_act  <= 1'b0;
            m_age  <= 0;
            m_ack  <= 1'b0;
            m_to   <= 1'b0;
            exp_q.delete();
        end else begin
            if (trigger_in && !(m_act && m_age == 0)) begin
                if (m_pend == PMAX) m_pend <= m_pend;
                else m_pend <= m_pend + 1;
            end else if (!trigger_in && m_act && m_age == 0) begin
                m_pend <= m_pend - 1;
            end
            if (clear_overflow) m_ovf <= 1'b0;
            if (trigger_in && !(m_act && m_age == 0) && m_pend == PMAX) m_ovf <= 1'b1;

            if (m_ack) begin
                m_ack <= 1'b0;
                m_to  <= 1'b0;
            end else if (!m_act) begin
                if (enable && m_pend != 0) begin
                    m_act <= 1'b1;
                    m_age <= 0;
                end
            end else if (m_age == 0) begin
                m_age <= 1;
            end else if (done_in) begin
                m_act <= 1'b0;
                m_ack <= 1'b1;
                exp_q.push_back(1'b0);
            end else if (m_age == T) begin
                m_act <= 1'b0;
                m_ack <= 1'b1;
                m_to  <= 1'b1;
                exp_q.push_back(1'b1);
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("start", start, m_act && m_age == 0);
            check_eq("busy", busy, m_act);
            check_eq("ack", ack, m_ack);
            check_eq("timeout", timeout, m_to);
            check_eq("pending", pending, m_pend);
            check_eq("overflow", overflow, m_ovf);
            if (ack) begin
                if (exp_q.size() == 0) check_eq("ack_unexpected", 1, 0);
                else check_eq("ack_to", timeout, exp_q.pop_front());
            end
        end
    end

    task automatic trig(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 trigger_in = 1'b1;
        end
        @(posedge clk); #1 trigger_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the first WAIT cycle (busy and not start).
    task automatic wait_in_wait();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy && !start) return;
        end
        check_eq("wait_reached", 0, 1);
    endtask

    // Called at a negedge: done_in is seen by the following rising edge only.
    task automatic pulse_done();
        done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        chk_on = 1'b1;
        idle(2);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pending", pending, 0);
        #1 rst = 1'b0;
        idle(3);

        // Single trigger, done in the first WAIT cycle.
        enable = 1'b1;
        trig(1);
        @(negedge clk);
        check_eq("single_pend", pending, 1);
        wait_in_wait();
        pulse_done();
        @(negedge clk);
        check_eq("single_ack", ack, 1);
        check_eq("single_to", timeout, 0);
        idle(3);

        // Queueing and saturation.
        enable = 1'b0;
        trig(3);
        @(negedge clk);
        check_eq("q_pend3", pending, 3);
        check_eq("q_ovf0", overflow, 0);
        check_eq("q_nostart", start, 0);
        trig(1);
        @(negedge clk);
        check_eq("q_ovf1", overflow, 1);
        check_eq("q_sat", pending, 3);
        @(posedge clk); #1 trigger_in = 1'b1; clear_overflow = 1'b1;
        @(posedge clk); #1 trigger_in = 1'b0; clear_overflow = 1'b0;
        @(negedge clk);
        check_eq("q_setwins", overflow, 1);
        @(posedge clk); #1 clear_overflow = 1'b1;
        @(posedge clk); #1 clear_overflow = 1'b0;
        @(negedge clk);
        check_eq("q_clear", overflow, 0);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_in_wait();
            check_eq("q_drain", pending, 2 - k);
            pulse_done();
        end
        idle(4);

        // Trigger coincident with START.
        enable = 1'b0;
        trig(1);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start) break;
        end
        trigger_in = 1'b1;
        @(posedge clk); #1 trigger_in = 1'b0;
        @(negedge clk);
        check_eq("incdec_pend", pending, 1);
        pulse_done();
        wait_in_wait();
        pulse_done();
        idle(4);

        // Timeout, then done on the expiry cycle.
        trig(1);
        wait_in_wait();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        check_eq("tmo_ack", ack, 1);
        check_eq("tmo_flag", timeout, 1);
        idle(2);
        trig(1);
        wait_in_wait();
        repeat (T - 1) @(negedge clk);
        pulse_done();
        @(negedge clk);
        check_eq("tie_ack", ack, 1);
        check_eq("tie_to", timeout, 0);
        idle(3);

        // Stray done in IDLE and enable drop during WAIT.
        @(negedge clk);
        pulse_done();
        @(negedge clk);
        check_eq("stray_ack", ack, 0);
        trig(2);
        wait_in_wait();
        enable = 1'b0;
        pulse_done();
        @(negedge clk);
        check_eq("endrop_ack", ack, 1);
        idle(8);
        @(negedge clk);
        check_eq("endrop_pend", pending, 1);
        enable = 1'b1;
        wait_in_wait();
        pulse_done();
        idle(4);

        // Reset during WAIT with pending=2 and overflow set.
        enable = 1'b0;
        trig(4);
        enable = 1'b1;
        wait_in_wait();
        check_eq("mid_pend2", pending, 2);
        check_eq("mid_ovf1", overflow, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_pend0", pending, 0);
        check_eq("mid_ovf0", overflow, 0);
        check_eq("mid_ack", ack, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(10);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            trigger_in     = ($urandom_range(0, 3) == 0);
            done_in        = ($urandom_range(0, 4) == 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            rst            = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        trigger_in = 1'b0;
        clear_overflow = 1'b0;
        enable = 1'b0;
        done_in = 1'b1;
        idle(20);
        done_in = 1'b0;
        idle(2);
        check_eq("ack_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
